acc_result_reader: RTL and testbench
====================================

ACC_RESULT_READER -- requirements
Module: acc_result_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, coefficient width (matches `DATA_SIZE_ARB`).
REQ-002 SHALL have parameter ADDR_W, default 11, accumulator read-address width (`RING_DEPTH`+1).
REQ-003 SHALL have parameter COUNT, default 2048, words per readout (2*`RING_SIZE`).
REQ-004 SHALL have parameter READ_LAT, default 1, accumulator read latency in cycles (1..4).
REQ-005 SHALL have port clk, input, 1, clock, all logic on rising edge.
REQ-006 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-007 SHALL have port acc_done, input, 1, accumulator finished; single-cycle pulse or level.
REQ-008 SHALL have port rd_en, output, 1, accumulator read strobe.
REQ-009 SHALL have port rd_addr, output, ADDR_W, accumulator read address.
REQ-010 SHALL have port rd_data, input, DATA_W, read data, valid exactly READ_LAT cycles after rd_en.
REQ-011 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, DATA_W), m_last (output, 1): the output stream.
REQ-012 SHALL have port busy, output, 1, readout in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse after the final word is accepted.
REQ-014 SHALL have ports checksum (output, DATA_W) and checksum_valid (output, 1).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FIN.
REQ-016 IDLE->RUN on the first cycle acc_done=1; the address counter loads 0.
REQ-017 In RUN, SHALL assert rd_en with rd_addr=n, for n=0..COUNT-1 ascending, exactly once each, whenever in-flight reads plus FIFO occupancy < READ_LAT+2.
REQ-018 SHALL capture rd_data READ_LAT cycles after each rd_en into an internal FIFO of depth READ_LAT+2; the FIFO SHALL never overflow.
REQ-019 m_valid=1 iff FIFO non-empty; m_data=FIFO head; a word transfers when m_valid&&m_ready.
REQ-020 m_valid, m_data, m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-021 m_last=1 only with the word from address COUNT-1.
REQ-022 With m_ready held 1, first m_valid SHALL occur READ_LAT+1 cycles after the acc_done cycle; sustained throughput one word per cycle.
REQ-023 RUN->FIN on the cycle the m_last word transfers; FIN SHALL assert done for one cycle, then ->IDLE.
REQ-024 busy=1 in RUN and FIN, else 0.
REQ-025 acc_done while in RUN or FIN SHALL be ignored; acc_done held high in IDLE after FIN SHALL start a new readout.
REQ-026 rd_addr SHALL not exceed COUNT-1; no rd_en after address COUNT-1 is issued.
REQ-027 Simultaneous FIFO push and pop SHALL keep occupancy unchanged.

Reset
REQ-028 With resetn=0 at a clock edge: state=IDLE, counters and FIFO cleared, rd_en=0, rd_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, checksum=0, checksum_valid=0.
REQ-029 Reset mid-readout SHALL abort the transfer; read data returning after reset SHALL be discarded; no done pulse.

Configuration
REQ-030 Macro ACC_READER_CHECKSUM_EN defined: checksum SHALL be the sum modulo 2^DATA_W of all transferred words of the current readout, cleared on IDLE->RUN; checksum_valid=1 from FIN until the next IDLE->RUN.
REQ-031 Macro ACC_READER_CHECKSUM_EN undefined: the checksum adder SHALL be absent; checksum and checksum_valid SHALL be constant 0.

Verification (COUNT=8, READ_LAT=1, memory model rd_data=3*addr)
REQ-032 acc_done pulse, m_ready=1 -> m_data 0,3,...,21 on 8 consecutive cycles starting 2 cycles after the pulse; m_last on 21; done one cycle later.
REQ-033 m_ready toggled 1/0 every cycle -> identical 8-word sequence, no loss or duplication, values stable during stalls, rd_addr never >7.
REQ-034 m_ready=0 for 20 cycles after acc_done -> at most 3 rd_en issued, m_valid=1 with m_data=0 held; release -> full sequence.
REQ-035 resetn=0 for 1 cycle after the 4th transfer -> all outputs 0 next cycle, no done; new acc_done -> full sequence from 0.
REQ-036 acc_done held high throughout -> back-to-back readouts, each ending with exactly one done pulse.
REQ-037 With ACC_READER_CHECKSUM_EN: checksum=84, checksum_valid=1 at done; without: checksum stays 0.

Source files
------------

// File: rtl/acc_result_reader.sv
// rtl/acc_result_reader.sv - Streams an accumulator readout through a credit-limited skid FIFO
//
// Optional feature macro: ACC_READER_CHECKSUM_EN (running checksum of transferred words).
//
// Ports:
//   clk, resetn            clock (rising edge), synchronous active-low reset
//   acc_done               accumulator finished (pulse or level); starts a readout from IDLE
//   rd_en, rd_addr         accumulator read strobe and address (0..COUNT-1)
//   rd_data                accumulator read data, valid READ_LAT cycles after rd_en
//   m_valid, m_ready,
//   m_data, m_last         output stream; m_last marks the word from address COUNT-1
//   busy                   readout in progress (RUN or FIN)
//   done                   one-cycle pulse after the final word is accepted
//   checksum,
//   checksum_valid         sum of transferred words, valid from FIN until the next start

module acc_result_reader #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 11,
    parameter int COUNT    = 2048,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              acc_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              checksum_valid
);

    // Enough slots to absorb every read that can be in flight when the sink stalls.
    localparam int DEPTH = READ_LAT + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [ADDR_W-1:0]   out_cnt;
    logic                all_issued;
    logic [READ_LAT-1:0] pipe;
    logic [CNT_W-1:0]    inflight;
    logic [CNT_W-1:0]    fifo_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;

    logic ret_valid, fifo_empty, issue, xfer, push, pop, start, finish;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ret_valid  = pipe[READ_LAT-1];
    assign fifo_empty = (fifo_cnt == '0);
    // Credit check: every outstanding read must have a guaranteed FIFO slot.
    assign issue      = (state == RUN) && !all_issued &&
                        (({1'b0, inflight} + {1'b0, fifo_cnt}) < (CNT_W + 1)'(DEPTH));
    assign xfer       = m_valid && m_ready;
    // Returning data bypasses the FIFO when it is empty and the sink takes it at once.
    assign push       = ret_valid && !(fifo_empty && m_ready);
    assign pop        = !fifo_empty && m_ready;
    assign start      = (state == IDLE) && acc_done;
    assign finish     = (state == RUN) && xfer && m_last;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc_done) state_nxt = RUN;
            RUN:     if (finish)   state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rd_en   = issue;
        rd_addr = addr_cnt;
        busy    = (state != IDLE);
        done    = (state == FIN);
        m_valid = !fifo_empty || ret_valid;
        m_data  = !fifo_empty ? mem[rd_ptr] : (ret_valid ? rd_data : '0);
        m_last  = m_valid && (out_cnt == ADDR_W'(COUNT - 1));
    end

    // Address / transfer counters and read-return tracking
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_cnt   <= '0;
            out_cnt    <= '0;
            all_issued <= 1'b0;
            pipe       <= '0;
            inflight   <= '0;
        end else begin
            if (start) begin
                addr_cnt   <= '0;
                out_cnt    <= '0;
                all_issued <= 1'b0;
            end else begin
                if (issue) begin
                    if (addr_cnt == ADDR_W'(COUNT - 1)) all_issued <= 1'b1;
                    else                                addr_cnt   <= addr_cnt + 1'b1;
                end
                if (xfer && !m_last) out_cnt <= out_cnt + 1'b1;
            end
            pipe[0] <= issue;
            for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
            inflight <= inflight + CNT_W'(issue) - CNT_W'(ret_valid);
        end
    end

    // Skid FIFO
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= rd_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef ACC_READER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    logic              sum_valid_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else if (start) begin
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            if (xfer)   sum_q       <= sum_q + m_data;
            if (finish) sum_valid_q <= 1'b1;
        end
    end

    assign checksum       = sum_q;
    assign checksum_valid = sum_valid_q;
`else
    assign checksum       = '0;
    assign checksum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_acc_result_reader.sv
// tb/tb_acc_result_reader.sv - Scoreboard testbench for acc_result_reader (COUNT=8, READ_LAT=1)

module tb_acc_result_reader;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int COUNT    = 8;
    localparam int READ_LAT = 1;

`ifdef ACC_READER_CHECKSUM_EN
    localparam logic [31:0] EXP_SUM   = 32'd84;
    localparam logic [31:0] EXP_SUM_V = 32'd1;
`else
    localparam logic [31:0] EXP_SUM   = 32'd0;
    localparam logic [31:0] EXP_SUM_V = 32'd0;
`endif

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              acc_done = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;
    logic              checksum_valid;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int rd_en_cnt = 0;
    int xfer_cnt = 0;
    int ready_mode = 0;   // 0: always ready, 1: toggle, 2: hold low

    logic [32:0] sb[$];   // {last, data}
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    acc_result_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .COUNT(COUNT), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .resetn(resetn), .acc_done(acc_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .checksum(checksum), .checksum_valid(checksum_valid)
    );

    always #5 clk = ~clk;

    // Accumulator memory model: rd_data = 3*addr, one cycle after rd_en
    always @(posedge clk) if (rd_en) rd_data <= 32'(rd_addr) * 32'd3;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_seq();
        for (int i = 0; i < COUNT; i++) sb.push_back({(i == COUNT - 1), 32'(3 * i)});
    endtask

    task automatic pulse();
        @(posedge clk); #1 acc_done = 1'b1;
        @(posedge clk); #1 acc_done = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (!busy && !m_valid && sb.size() == 0) break;
        end
        chk({name, "_timeout"}, (n >= 200), 0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (rd_en) begin
                rd_en_cnt++;
                chk("rd_addr_max", (rd_addr > 4'(COUNT - 1)), 0);
            end
            if (m_valid && m_ready) begin
                xfer_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_word", m_data, 32'hFFFF_FFFF);
                end else begin
                    logic [32:0] e;
                    e = sb.pop_front();
                    chk("m_data", m_data, e[31:0]);
                    chk("m_last", m_last, 32'(e[32]));
                end
            end
            if (done) begin
                done_cnt++;
                chk("checksum", checksum, EXP_SUM);
                chk("checksum_valid", checksum_valid, EXP_SUM_V);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_checksum_valid", checksum_valid, 0);

        // Single pulse, always ready: exact latency
        ready_mode = 0; done_cnt = 0;
        push_seq();
        @(posedge clk); #1 acc_done = 1'b1;
        @(negedge clk);
        chk("t1_c0_valid", m_valid, 0);
        @(posedge clk); #1 acc_done = 1'b0;
        @(negedge clk);
        chk("t1_c1_busy", busy, 1);
        chk("t1_c1_rd_en", rd_en, 1);
        chk("t1_c1_rd_addr", rd_addr, 0);
        chk("t1_c1_valid", m_valid, 0);
        @(negedge clk);
        chk("t1_c2_valid", m_valid, 1);
        chk("t1_c2_data", m_data, 0);
        repeat (7) @(negedge clk);
        chk("t1_c9_last", m_last, 1);
        chk("t1_c9_data", m_data, 21);
        @(negedge clk);
        chk("t1_c10_done", done, 1);
        @(negedge clk);
        chk("t1_c11_done", done, 0);
        chk("t1_c11_busy", busy, 0);
        chk("t1_done_cnt", done_cnt, 1);

        // Toggling ready
        ready_mode = 1; done_cnt = 0; xfer_cnt = 0;
        push_seq();
        pulse();
        wait_idle("t2");
        chk("t2_xfers", xfer_cnt, 8);
        chk("t2_done_cnt", done_cnt, 1);

        // Long stall right after start
        ready_mode = 2; done_cnt = 0; rd_en_cnt = 0;
        push_seq();
        pulse();
        repeat (19) @(negedge clk);
        chk("t3_rd_en_le3", (rd_en_cnt <= 3), 1);
        chk("t3_valid", m_valid, 1);
        chk("t3_data", m_data, 0);
        ready_mode = 0;
        wait_idle("t3");
        chk("t3_rd_en_total", rd_en_cnt, 8);
        chk("t3_done_cnt", done_cnt, 1);

        // Reset after the 4th transfer
        ready_mode = 0; done_cnt = 0; xfer_cnt = 0;
        push_seq();
        pulse();
        begin
            int n;
            for (n = 0; n < 50; n++) begin
                @(negedge clk); #1;
                if (xfer_cnt == 4) break;
            end
            chk("t4_wait4_timeout", (n >= 50), 0);
        end
        resetn = 1'b0;
        sb.delete();
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        chk("t4_rd_en", rd_en, 0);
        chk("t4_m_valid", m_valid, 0);
        chk("t4_m_data", m_data, 0);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        repeat (4) @(negedge clk);
        chk("t4_no_done", done_cnt, 0);
        chk("t4_still_idle", busy, 0);
        push_seq();
        pulse();
        wait_idle("t4");
        chk("t4_done_cnt", done_cnt, 1);

        // acc_done held high: back-to-back readouts
        ready_mode = 0; done_cnt = 0;
        push_seq();
        push_seq();
        @(posedge clk); #1 acc_done = 1'b1;
        begin
            int n;
            for (n = 0; n < 100; n++) begin
                @(negedge clk); #1;
                if (done_cnt == 2) break;
            end
            chk("t5_wait_timeout", (n >= 100), 0);
        end
        @(posedge clk); #1 acc_done = 1'b0;
        wait_idle("t5");
        chk("t5_done_cnt", done_cnt, 2);
        chk("t5_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
